// File: rtl/rng_capture_bank_if.sv
// Output stream of captured random values: a valid/ready record of
// {channel, value} presented by the capture bank to downstream game logic.
interface rng_capture_bank_if #(
  parameter int WIDTH  = 4,
  parameter int CHAN_W = 1
);
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_value;
  logic [CHAN_W-1:0] out_chan;

  modport master (output out_valid, output out_value, output out_chan, input out_ready);
  modport slave  (input out_valid, input out_value, input out_chan, output out_ready);
endinterface

// File: rtl/rng_capture_bank.sv
// Multi-channel debounced button capture of a shared RNG value, with per-channel
// holding registers and a channel-tagged first-word fall-through FIFO.
module rng_capture_bank #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int DEBOUNCE = 4,
  parameter int DEPTH    = 4,
  localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       btn,
  input  logic [1:0]                edge_mode,
  input  logic [WIDTH-1:0]          rng_value,
  input  logic                      clr_overflow,
  output logic [CHANNELS*WIDTH-1:0] stable_value,
  output logic [PTR_W:0]            fifo_count,
  output logic                      overflow,
  rng_capture_bank_if.master        out
);

  typedef enum logic [1:0] {
    EDGE_RELEASE = 2'b00,
    EDGE_PRESS   = 2'b01,
    EDGE_BOTH    = 2'b10,
    EDGE_OFF     = 2'b11
  } edge_mode_e;

  localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEBOUNCE - 1);

  logic [CHANNELS-1:0] sync_a, sync_b, db, pending;
  logic [CNT_W-1:0]    cnt      [CHANNELS];
  logic [WIDTH-1:0]    stable_q [CHANNELS];

  logic [CHANNELS-1:0] fire, qual, push_mask;
  logic [CHAN_W-1:0]   push_sel;
  logic                push_req, push, pop, valid, lost;

  logic [WIDTH-1:0]    mem_value [DEPTH];
  logic [CHAN_W-1:0]   mem_chan  [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;

  // Debounce acceptance and edge qualification; sync_b is the synchronised level.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    fire = '0;
    qual = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      fire[i] = (sync_b[i] != db[i]) && (cnt[i] == CNT_TOP);
      unique case (edge_mode_e'(edge_mode))
        EDGE_RELEASE: qual[i] = fire[i] && !sync_b[i];
        EDGE_PRESS:   qual[i] = fire[i] &&  sync_b[i];
        EDGE_BOTH:    qual[i] = fire[i];
        default:      qual[i] = 1'b0;
      endcase
    end
  end

  // Fixed priority: lowest-indexed pending channel wins the single push slot.
  always_comb begin
    push_req = 1'b0;
    push_sel = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        push_req = 1'b1;
        push_sel = CHAN_W'(i);
      end
    end
  end

  assign valid = (fifo_count != '0);
  assign pop   = valid && out.out_ready;
  assign push  = push_req && ((fifo_count != FULL) || pop);

  always_comb begin
    push_mask = '0;
    if (push) push_mask[push_sel] = 1'b1;
  end

  // A capture is lost only when the older pending value never made it into the FIFO.
  assign lost = |(qual & pending & ~push_mask);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sync_a     <= '0;
      sync_b     <= '0;
      db         <= '0;
      pending    <= '0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i]      <= '0;
        stable_q[i] <= '0;
      end
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;

      for (int i = 0; i < CHANNELS; i++) begin
        if (sync_b[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (fire[i]) begin
          db[i]  <= sync_b[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end

        // A fresh capture on the same edge as this channel's push re-arms pending.
        if (push_mask[i]) pending[i] <= 1'b0;
        if (qual[i]) begin
          stable_q[i] <= rng_value;
          pending[i]  <= 1'b1;
        end
      end

      if (lost)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: storage is not reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_value[wr_ptr] <= stable_q[push_sel];
      mem_chan[wr_ptr]  <= push_sel;
    end
  end

  assign out.out_valid = valid;
  assign out.out_value = valid ? mem_value[rd_ptr] : '0;
  assign out.out_chan  = valid ? mem_chan[rd_ptr]  : '0;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_stable
    assign stable_value[g*WIDTH +: WIDTH] = stable_q[g];
  end

endmodule

// File: tb/tb_rng_capture_bank.sv
// Randomised and directed bench for rng_capture_bank, checked every cycle against
// a queue-based behavioural model of debounce, capture, arbitration and FIFO.
module tb_rng_capture_bank;
  localparam int WIDTH    = 4;
  localparam int CHANNELS = 2;
  localparam int DEBOUNCE = 4;
  localparam int DEPTH    = 4;
  localparam int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [CHANNELS-1:0]       btn;
  logic [1:0]                edge_mode;
  logic [WIDTH-1:0]          rng_value;
  logic                      clr_overflow;
  logic [CHANNELS*WIDTH-1:0] stable_value;
  logic [$clog2(DEPTH):0]    fifo_count;
  logic                      overflow;

  rng_capture_bank_if #(.WIDTH(WIDTH), .CHAN_W(CHAN_W)) out_if ();

  rng_capture_bank #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEBOUNCE(DEBOUNCE), .DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .edge_mode    (edge_mode),
    .rng_value    (rng_value),
    .clr_overflow (clr_overflow),
    .stable_value (stable_value),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .out          (out_if)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct { int ch; int val; } entry_t;
  entry_t m_q[$];
  int     m_sv   [CHANNELS];
  bit     m_db   [CHANNELS];
  bit     m_pend [CHANNELS];
  bit     m_ovf;
  bit     m_pipe [CHANNELS][$];  // raw samples still inside the two-stage synchroniser
  bit     m_win  [CHANNELS][$];  // most recent DEBOUNCE synchronised samples

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      m_sv[ch]   = 0;
      m_db[ch]   = 1'b0;
      m_pend[ch] = 1'b0;
      m_pipe[ch] = '{1'b0, 1'b0};
      m_win[ch].delete();
    end
  endtask

  // One rising edge of the behavioural model, using the inputs present at that edge.
  task automatic model_edge();
    bit pend_pre [CHANNELS];
    bit pop, lost, s, all_diff, press, qualifies;
    int push_ch;
    if (rst) begin
      model_reset();
      return;
    end
    for (int ch = 0; ch < CHANNELS; ch++) pend_pre[ch] = m_pend[ch];
    pop  = (m_q.size() != 0) && out_if.out_ready;
    lost = 1'b0;

    push_ch = -1;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (m_pend[ch]) begin
        push_ch = ch;
        break;
      end
    end
    if (push_ch >= 0 && !(m_q.size() < DEPTH || pop)) push_ch = -1;
    if (pop) void'(m_q.pop_front());
    if (push_ch >= 0) begin
      m_q.push_back('{push_ch, m_sv[push_ch]});
      m_pend[push_ch] = 1'b0;
    end

    // A change is accepted once the last DEBOUNCE synchronised samples all disagree with db.
    for (int ch = 0; ch < CHANNELS; ch++) begin
      s = m_pipe[ch].pop_front();
      m_pipe[ch].push_back(btn[ch]);
      m_win[ch].push_back(s);
      if (m_win[ch].size() > DEBOUNCE) void'(m_win[ch].pop_front());
      all_diff = (m_win[ch].size() == DEBOUNCE);
      foreach (m_win[ch][k]) if (m_win[ch][k] == m_db[ch]) all_diff = 1'b0;
      if (all_diff) begin
        m_db[ch]  = !m_db[ch];
        press     = m_db[ch];
        qualifies = (edge_mode == 2'b10) || (edge_mode == 2'b01 && press) ||
                    (edge_mode == 2'b00 && !press);
        if (qualifies) begin
          if (pend_pre[ch] && push_ch != ch) lost = 1'b1;
          m_sv[ch]   = int'(rng_value);
          m_pend[ch] = 1'b1;
        end
      end
    end

    if (lost)              m_ovf = 1'b1;
    else if (clr_overflow) m_ovf = 1'b0;
  endtask

  task automatic compare_outputs();
    logic [CHANNELS*WIDTH-1:0] exp_sv;
    for (int ch = 0; ch < CHANNELS; ch++) exp_sv[ch*WIDTH +: WIDTH] = WIDTH'(m_sv[ch]);
    check("stable_value", stable_value, exp_sv);
    check("fifo_count", fifo_count, m_q.size());
    check("out_valid", out_if.out_valid, m_q.size() != 0);
    check("out_value", out_if.out_value, (m_q.size() != 0) ? m_q[0].val : 0);
    check("out_chan", out_if.out_chan, (m_q.size() != 0) ? m_q[0].ch : 0);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_outputs();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int ready_pct;
    rst = 1'b1; btn = '0; edge_mode = 2'b01; rng_value = '0; clr_overflow = 1'b0;
    out_if.out_ready = 1'b0;
    model_reset();
    step(2);
    check("rst_stable", stable_value, '0);
    check("rst_valid", out_if.out_valid, 1'b0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 1'b0);
    rst = 1'b0;

    // Release mode: the press is ignored, the release captures A
    edge_mode = 2'b00; rng_value = 4'hA; btn[0] = 1'b1;
    step(20);
    check("release_no_press_entry", fifo_count, 0);
    btn[0] = 1'b0;
    lat = 0;
    while (!out_if.out_valid && lat < 50) begin
      step();
      lat++;
    end
    check("release_latency", lat, 7);
    check("release_value", stable_value[3:0], 4'hA);
    check("release_head", {out_if.out_chan, out_if.out_value}, {1'b0, 4'hA});
    out_if.out_ready = 1'b1;
    step();
    check("release_popped", fifo_count, 0);
    out_if.out_ready = 1'b0;

    // Bounce rejection on channel 1, then a single press
    edge_mode = 2'b01; rng_value = 4'h7;
    for (int i = 0; i < 12; i++) begin
      btn[1] = ((i / 2) % 2) == 0;
      step();
    end
    check("bounce_no_event", fifo_count, 0);
    btn[1] = 1'b1;
    lat = 0;
    while (stable_value[7:4] != 4'h7 && lat < 50) begin
      step();
      lat++;
    end
    check("bounce_capture_latency", lat, DEBOUNCE + 2);
    step(3);
    check("bounce_one_entry", fifo_count, 1);
    check("bounce_chan", out_if.out_chan, 1);
    out_if.out_ready = 1'b1;
    step(2);

    // Simultaneous release on both channels in both-edge mode
    edge_mode = 2'b10; btn = 2'b11;
    step(12);
    out_if.out_ready = 1'b0; rng_value = 4'h5; btn = 2'b00;
    lat = 0;
    while (fifo_count == 0 && lat < 50) begin
      step();
      lat++;
    end
    check("simul_first", {fifo_count, out_if.out_chan}, {3'd1, 1'b0});
    step();
    check("simul_second", fifo_count, 2);
    check("simul_values", stable_value, 8'h55);
    out_if.out_ready = 1'b1;
    step(3);
    out_if.out_ready = 1'b0;

    // Fill the FIFO, hold a pending capture, then overflow
    edge_mode = 2'b01;
    for (int k = 0; k < DEPTH + 2; k++) begin
      rng_value = WIDTH'($urandom);
      btn[0] = 1'b1; step(8);
      btn[0] = 1'b0; step(8);
    end
    check("full_count", fifo_count, DEPTH);
    check("full_overflow", overflow, 1'b1);
    rng_value = WIDTH'($urandom);
    btn[0] = 1'b1;
    step(DEBOUNCE + 1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("set_beats_clear", overflow, 1'b1);
    btn[0] = 1'b0;
    step(8);
    out_if.out_ready = 1'b1;
    step();
    check("push_pop_full", fifo_count, DEPTH);
    out_if.out_ready = 1'b0;
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("overflow_cleared", overflow, 1'b0);
    out_if.out_ready = 1'b1;
    step(8);
    out_if.out_ready = 1'b0;

    // Mid-operation reset with three queued entries and channel 1 pending
    for (int k = 0; k < 3; k++) begin
      btn[0] = 1'b1; step(8);
      btn[0] = 1'b0; step(8);
    end
    check("midrst_queued", fifo_count, 3);
    btn[1] = 1'b1;
    lat = 0;
    while (!m_pend[1] && lat < 50) begin
      step();
      lat++;
    end
    rst = 1'b1; btn[1] = 1'b0;
    step(2);
    rst = 1'b0;
    check("midrst_empty", fifo_count, 0);
    step(20);
    check("midrst_no_entry", out_if.out_valid, 1'b0);

    // Capture disabled
    edge_mode = 2'b11;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(5) == 0) btn = CHANNELS'($urandom);
      rng_value = WIDTH'($urandom);
      step();
    end
    check("disabled_no_entry", fifo_count, 0);

    // Randomised traffic against the model
    ready_pct = 50;
    for (int i = 0; i < 2500; i++) begin
      if (i % 200 == 0) ready_pct = $urandom_range(100);
      for (int ch = 0; ch < CHANNELS; ch++)
        if ($urandom_range(7) == 0) btn[ch] = !btn[ch];
      if ($urandom_range(49) == 0) edge_mode = 2'($urandom);
      rng_value        = WIDTH'($urandom);
      out_if.out_ready = ($urandom_range(99) < ready_pct);
      clr_overflow     = ($urandom_range(19) == 0);
      rst              = ($urandom_range(399) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
